// File: rtl/jt900h_div_pkg.sv
// Shared definitions for the TLCS-900H DIV/DIVS sequential divider.
// State encodings, latched control bundle and magnitude helpers.
package jt900h_div_pkg;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_ZCHK = 2'd1;
  localparam logic [1:0] DIV_ITER = 2'd2;
  localparam logic [1:0] DIV_FIX  = 2'd3;

  typedef struct packed {
    logic wmode;
    logic sgn;
    logic dsign;
    logic qsign;
  } div_ctl_t;

  function automatic logic [7:0] abs8(
    input logic [7:0] x,
    input logic       s
  );
    return (s && x[7]) ? -x : x;
  endfunction

  function automatic logic [15:0] abs16(
    input logic [15:0] x,
    input logic        s
  );
    return (s && x[15]) ? -x : x;
  endfunction

  function automatic logic [31:0] abs32(
    input logic [31:0] x,
    input logic        s
  );
    return (s && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/jt900h_div.sv
// TLCS-900H DIV/DIVS unit: restoring division on magnitudes,
// one quotient bit per enabled clock, sign fix-up at the end.
module jt900h_div
  import jt900h_div_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        start,
  input  logic        sign,
  input  logic [1:0]  w,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic        v
);

  logic [1:0]  st;
  div_ctl_t    ctl;
  logic [31:0] acc;
  logic [15:0] dvs;
  logic [3:0]  cnt;
  logic        ovf;
  logic        zdiv;

  logic        valid;
  logic        msb_d;
  logic        msb_s;
  logic [31:0] mag_d;
  logic [15:0] mag_s;

  assign valid = (w == 2'b01) || (w == 2'b10);
  assign msb_d = w[0] ? op0[15] : op0[31];
  assign msb_s = w[0] ? op1[7]  : op1[15];
  assign mag_d = w[0] ? {16'd0, abs16(op0[15:0], sign)}
                      : abs32(op0, sign);
  assign mag_s = w[0] ? {8'd0, abs8(op1[7:0], sign)}
                      : abs16(op1, sign);

  // acc holds {rem, dividend/quotient}; byte mode uses acc[15:0]
  logic [16:0] part;
  logic [15:0] diff;
  logic [15:0] rem_n;
  logic        take;
  logic [31:0] acc_n;

  assign part  = ctl.wmode ? acc[31:15] : {8'd0, acc[15:7]};
  assign take  = part >= {1'b0, dvs};
  assign diff  = part[15:0] - dvs;
  assign rem_n = take ? diff : part[15:0];
  assign acc_n = ctl.wmode
               ? {rem_n, acc[14:0], take}
               : {16'd0, rem_n[7:0], acc[6:0], take};

  logic        ovf_n;
  logic [15:0] rawlo;
  logic [31:0] zacc;

  assign ovf_n = ctl.wmode ? (acc[31:16] >= dvs)
                           : (acc[15:8] >= dvs[7:0]);
  // undo the magnitude to recover the raw dividend low bits
  assign rawlo = ctl.dsign ? -acc[15:0] : acc[15:0];
  assign zacc  = ctl.wmode ? {rawlo, 16'hFFFF}
                           : {16'd0, rawlo[7:0], 8'hFF};

  logic [15:0] q;
  logic [15:0] r;
  logic [15:0] half;
  logic [15:0] qf;
  logic [15:0] rf;
  logic        sovf;
  logic [31:0] fix_d;

  assign q     = ctl.wmode ? acc[15:0]  : {8'd0, acc[7:0]};
  assign r     = ctl.wmode ? acc[31:16] : {8'd0, acc[15:8]};
  assign half  = ctl.wmode ? 16'h8000 : 16'h0080;
  assign sovf  = ctl.sgn & (ctl.qsign ? (q > half)
                                      : (q >= half));
  assign qf    = ctl.qsign ? -q : q;
  assign rf    = ctl.dsign ? -r : r;
  assign fix_d = ctl.wmode ? {rf, qf}
                           : {16'd0, rf[7:0], qf[7:0]};

  // busy stays high through the done pulse
  assign busy = (st != DIV_IDLE) || done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= DIV_IDLE;
      ctl  <= '0;
      acc  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      zdiv <= 1'b0;
      done <= 1'b0;
      dout <= '0;
      v    <= 1'b0;
    end else if (cen) begin
      done <= 1'b0;
      unique case (st)
        DIV_IDLE: begin
          if (start && valid && !done) begin
            ctl.wmode <= w[1];
            ctl.sgn   <= sign;
            ctl.dsign <= sign & msb_d;
            ctl.qsign <= sign & (msb_d ^ msb_s);
            acc       <= mag_d;
            dvs       <= mag_s;
            st        <= DIV_ZCHK;
          end
        end
        DIV_ZCHK: begin
          if (dvs == 16'd0) begin
            zdiv <= 1'b1;
            acc  <= zacc;
            st   <= DIV_FIX;
          end else begin
            zdiv <= 1'b0;
            ovf  <= ovf_n;
            cnt  <= ctl.wmode ? 4'd15 : 4'd7;
            st   <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          acc <= acc_n;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) st <= DIV_FIX;
        end
        DIV_FIX: begin
          done <= 1'b1;
          v    <= zdiv | ovf | sovf;
          dout <= zdiv ? acc : fix_d;
          st   <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_div.sv
// Self-checking bench for jt900h_div against an arithmetic
// reference model, with directed vectors and random traffic.
module tb_jt900h_div;

  logic        rst   = 1'b1;
  logic        clk   = 1'b0;
  logic        cen   = 1'b0;
  logic        start = 1'b0;
  logic        sign  = 1'b0;
  logic [1:0]  w     = 2'b00;
  logic [31:0] op0   = '0;
  logic [15:0] op1   = '0;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic        v;

  jt900h_div dut (
    .rst  (rst),
    .clk  (clk),
    .cen  (cen),
    .start(start),
    .sign (sign),
    .w    (w),
    .op0  (op0),
    .op1  (op1),
    .busy (busy),
    .done (done),
    .dout (dout),
    .v    (v)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 30)
        $display("FAIL %s: got %h expected %h",
                 name, act, exp);
    end
  endtask

  // quotient/remainder from plain integer division on the operands
  function automatic void model(
    input  bit          s,
    input  bit          byte_m,
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic [31:0] d,
    output bit          vv,
    output bit          dok,
    output int          lat
  );
    longint n, dv, ds, ad, as, aq, ar, q, r;
    logic [15:0] qv, rv;
    bit neg;
    n = byte_m ? 8 : 16;
    if (byte_m) begin
      dv = s ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      ds = s ? longint'($signed(b[7:0]))  : longint'(b[7:0]);
    end else begin
      dv = s ? longint'($signed(a)) : longint'(a);
      ds = s ? longint'($signed(b)) : longint'(b);
    end
    if (ds == 0) begin
      vv  = 1;
      dok = 1;
      lat = 2;
      q   = (longint'(1) << n) - 1;
      r   = longint'(a) & ((longint'(1) << n) - 1);
    end else begin
      ad  = dv < 0 ? -dv : dv;
      as  = ds < 0 ? -ds : ds;
      aq  = ad / as;
      ar  = ad % as;
      neg = (dv < 0) != (ds < 0);
      vv  = (aq >= (longint'(1) << n)) ||
            (s && (neg ? aq > (longint'(1) << (n - 1))
                       : aq > (longint'(1) << (n - 1)) - 1));
      dok = aq < (longint'(1) << n);
      lat = int'(n) + 2;
      q   = neg ? -aq : aq;
      r   = dv < 0 ? -ar : ar;
    end
    qv = q[15:0];
    rv = r[15:0];
    d  = byte_m ? {16'h0, rv[7:0], qv[7:0]} : {rv, qv};
  endfunction

  bit          pending, exp_done, have_dout, exp_v;
  bit          p_v, p_ok, mbusy, prod;
  int          lat, exp_lat;
  logic [31:0] exp_dout, p_dout;

  // compare process: outputs sampled mid-cycle every clock
  always @(negedge clk) begin
    if (rst) begin
      pending   = 0;
      exp_done  = 0;
      exp_dout  = '0;
      exp_v     = 0;
      have_dout = 1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dout", dout, 32'd0);
      chk("rst_v", {31'd0, v}, 32'd0);
    end else begin
      mbusy = pending | exp_done;
      prod  = 0;
      if (cen) begin
        if (pending) begin
          lat++;
          if (lat == exp_lat) prod = 1;
        end
        exp_done = prod;
        if (prod) begin
          pending   = 0;
          exp_dout  = p_dout;
          exp_v     = p_v;
          have_dout = p_ok;
        end else if (start && !mbusy &&
                     (w == 2'b01 || w == 2'b10)) begin
          model(sign, w[0], op0, op1,
                p_dout, p_v, p_ok, exp_lat);
          pending = 1;
          lat     = 0;
        end
      end
      chk("done", {31'd0, done}, {31'd0, exp_done});
      chk("busy", {31'd0, busy},
          {31'd0, pending | exp_done});
      chk("v", {31'd0, v}, {31'd0, exp_v});
      if (have_dout) chk("dout", dout, exp_dout);
    end
  end

  task automatic drive(
    input bit          c,
    input bit          st_v,
    input bit          sg,
    input logic [1:0]  ww,
    input logic [31:0] a,
    input logic [15:0] b
  );
    @(negedge clk);
    #1;
    cen   = c;
    start = st_v;
    sign  = sg;
    w     = ww;
    op0   = a;
    op1   = b;
  endtask

  task automatic run_op(
    input string       name,
    input bit          sg,
    input logic [1:0]  ww,
    input logic [31:0] a,
    input logic [15:0] b,
    input logic [31:0] lit,
    input logic [31:0] mask,
    input bit          lit_v,
    input int          lit_lat,
    input bit          tog,
    input bit          noise
  );
    int wall;
    bit seen;
    wall = -1;
    seen = 0;
    drive(1, 0, 0, 2'b00, '0, '0);
    drive(1, 1, sg, ww, a, b);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      wall++;
      if (done) begin
        seen = 1;
        break;
      end
      cen   = tog ? ((wall + 1) % 2 == 0) : 1'b1;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        sign = 1'($urandom);
        w    = 2'($urandom);
        op0  = $urandom;
        op1  = 16'($urandom);
      end
    end
    chk({name, "_seen"}, {31'd0, seen}, 32'd1);
    chk({name, "_lat"}, wall, lit_lat * (tog ? 2 : 1));
    chk({name, "_dout"}, dout & mask, lit & mask);
    chk({name, "_v"}, {31'd0, v}, {31'd0, lit_v});
    // start while done is visible must be ignored
    cen   = 1'b1;
    start = noise;
    w     = 2'b01;
    drive(1, 0, 0, 2'b00, '0, '0);
    drive(1, 0, 0, 2'b00, '0, '0);
  endtask

  logic [31:0] md;
  bit          mv, mok;
  int          ml, dc;
  logic [1:0]  rw;

  initial begin
    // pin the model to hand-computed results
    model(0, 1, 32'h0064, 16'h07, md, mv, mok, ml);
    chk("m_byte_d", md, 32'h0000020E);
    chk("m_byte_lat", ml, 10);
    model(0, 0, 32'h00010000, 16'h0003, md, mv, mok, ml);
    chk("m_word_d", md, 32'h00015555);
    chk("m_word_lat", ml, 18);
    model(0, 1, 32'h1234, 16'h00, md, mv, mok, ml);
    chk("m_dz_d", md, 32'h000034FF);
    chk("m_dz_v", {31'd0, mv}, 32'd1);
    model(1, 1, 32'hFFF9, 16'h02, md, mv, mok, ml);
    chk("m_neg_d", md, 32'h0000FFFD);
    model(1, 1, 32'h0080, 16'h01, md, mv, mok, ml);
    chk("m_ovfs_v", {31'd0, mv}, 32'd1);
    model(1, 1, 32'hFF80, 16'h01, md, mv, mok, ml);
    chk("m_min_v", {31'd0, mv}, 32'd0);

    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    run_op("byte_u", 0, 2'b01, 32'h0064, 16'h07,
           32'h0000020E, 32'hFFFFFFFF, 0, 10, 0, 0);
    run_op("word_u", 0, 2'b10, 32'h00010000, 16'h0003,
           32'h00015555, 32'hFFFFFFFF, 0, 18, 0, 0);
    run_op("dz", 0, 2'b01, 32'h1234, 16'h00,
           32'h000034FF, 32'hFFFFFFFF, 1, 2, 0, 0);
    run_op("ovf_u", 0, 2'b01, 32'h0200, 16'h02,
           32'h0, 32'h0, 1, 10, 0, 0);
    run_op("ovf_s", 1, 2'b01, 32'h0080, 16'h01,
           32'h0, 32'h0, 1, 10, 0, 0);
    run_op("min_s", 1, 2'b01, 32'hFF80, 16'h01,
           32'h80, 32'hFF, 0, 10, 0, 0);
    run_op("neg_s", 1, 2'b01, 32'hFFF9, 16'h02,
           32'hFFFD, 32'hFFFF, 0, 10, 0, 0);
    run_op("noise", 0, 2'b10, 32'h00010000, 16'h0003,
           32'h00015555, 32'hFFFFFFFF, 0, 18, 0, 1);
    run_op("cen50", 0, 2'b10, 32'h00010000, 16'h0003,
           32'h00015555, 32'hFFFFFFFF, 0, 18, 1, 0);
    run_op("cen50n", 1, 2'b01, 32'hFFF9, 16'h02,
           32'hFFFD, 32'hFFFF, 0, 10, 1, 1);

    // reset after ZCHK plus five iterations
    drive(1, 0, 0, 2'b00, '0, '0);
    drive(1, 1, 0, 2'b10, 32'h00FF1234, 16'h0101);
    repeat (6) drive(1, 0, 0, 2'b00, '0, '0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_dout", dout, 32'd0);
    rst = 1'b0;
    dc  = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1, 0, 0, 2'b00, '0, '0);
      if (done) dc++;
    end
    chk("arst_nodone", dc, 0);

    for (int i = 0; i < 3000; i++) begin
      rw = ($urandom % 8 == 0) ? 2'($urandom)
         : (($urandom % 2) ? 2'b01 : 2'b10);
      drive(($urandom % 4) != 0,
            ($urandom % 3) == 0,
            1'($urandom),
            rw,
            $urandom >> $urandom_range(0, 24),
            ($urandom % 10 == 0) ? 16'h0
              : 16'($urandom >> $urandom_range(0, 12)));
    end
    for (int i = 0; i < 40; i++)
      drive(1, 0, 0, 2'b00, '0, '0);
    chk("drain", {31'd0, pending}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
